// File: rtl/mutative_reconfig_ctrl_pkg.sv
// Shared types and geometry for the mutative cache: associativity codes,
// reconfiguration FSM states and array dimensions.
package mutative_types;

    localparam int unsigned WAYS         = 8;
    localparam int unsigned SET_SIZE     = 16;
    localparam int unsigned SET_IDX_BITS = $clog2(SET_SIZE);
    localparam int unsigned WAY_IDX_BITS = $clog2(WAYS);

    typedef enum logic [1:0] {
        SETUP_DM = 2'b00,
        SETUP_2W = 2'b01,
        SETUP_4W = 2'b10,
        SETUP_8W = 2'b11
    } setup_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SAME,
        ST_DRAIN,
        ST_READ,
        ST_CAPTURE,
        ST_SCAN,
        ST_WB,
        ST_INVAL,
        ST_COMMIT
    } reconfig_state_t;

endpackage

// File: rtl/mutative_reconfig_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted bit and a
// flag when no bit is set.
module mutative_prio_enc
    import mutative_types::*;
#(
    parameter int unsigned W  = WAYS,
    parameter int unsigned IW = WAY_IDX_BITS
) (
    input  logic [W-1:0]  i_vec,
    output logic [IW-1:0] o_idx_c,
    output logic          o_none_c
);

    // Scan from the top down so the last hit written is the lowest bit.
    always_comb begin
        o_idx_c  = '0;
        o_none_c = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx_c  = IW'(i);
                o_none_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mutative_reconfig_ctrl.sv
// Associativity reconfiguration sequencer: drains the cache, sweeps every set
// writing back dirty lines and invalidating, clears PLRU, then commits setup.
module mutative_reconfig_ctrl
    import mutative_types::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_req,
    input  logic [1:0]              cfg_setup,
    output logic                    cfg_ready,
    output logic                    cfg_done,
    input  logic                    cache_idle,
    output logic                    stall_cache,
    output logic [1:0]              setup,
    output logic [SET_IDX_BITS-1:0] sweep_set,
    output logic                    sweep_rd,
    input  logic [WAYS-1:0]         line_valid,
    input  logic [WAYS-1:0]         line_dirty,
    output logic                    wb_req,
    output logic [WAY_IDX_BITS-1:0] wb_way,
    input  logic                    wb_ack,
    output logic                    inval_we,
    output logic                    plru_rst
);

    reconfig_state_t         r_state;
    reconfig_state_t         w_state_nxt;
    setup_t                  r_setup;
    setup_t                  r_target;
    logic [SET_IDX_BITS-1:0] r_sweep_set;
    logic [WAYS-1:0]         r_pending;
    logic [WAY_IDX_BITS-1:0] r_wb_way;

    logic r_cfg_ready, r_cfg_done, r_stall, r_sweep_rd, r_wb_req, r_inval_we, r_plru_rst;
    logic w_cfg_ready, w_cfg_done, w_stall, w_sweep_rd, w_wb_req, w_inval_we, w_plru_rst;

    logic [WAY_IDX_BITS-1:0] w_low_idx;
    logic                    w_none;
    logic                    w_last_set;
    logic                    w_same;

    assign w_last_set = (r_sweep_set == SET_IDX_BITS'(SET_SIZE - 1));
    assign w_same     = (setup_t'(cfg_setup) == r_setup);

    mutative_prio_enc #(
        .W  (WAYS),
        .IW (WAY_IDX_BITS)
    ) u_prio_enc (
        .i_vec    (r_pending),
        .o_idx_c  (w_low_idx),
        .o_none_c (w_none)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus output decode of that state; outputs are registered below.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (cfg_req) w_state_nxt = w_same ? ST_SAME : ST_DRAIN;
            ST_SAME:    w_state_nxt = ST_IDLE;
            ST_DRAIN:   if (cache_idle) w_state_nxt = ST_READ;
            ST_READ:    w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_SCAN;
            ST_SCAN:    w_state_nxt = w_none ? ST_INVAL : ST_WB;
            ST_WB:      if (wb_ack) w_state_nxt = ST_SCAN;
            ST_INVAL:   w_state_nxt = w_last_set ? ST_COMMIT : ST_READ;
            ST_COMMIT:  w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase

        w_cfg_ready = (w_state_nxt == ST_IDLE);
        w_stall     = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_SAME);
        w_cfg_done  = (w_state_nxt == ST_SAME) || (w_state_nxt == ST_COMMIT);
        w_sweep_rd  = (w_state_nxt == ST_READ);
        w_wb_req    = (w_state_nxt == ST_WB);
        w_inval_we  = (w_state_nxt == ST_INVAL);
        w_plru_rst  = (w_state_nxt == ST_COMMIT);
    end

    // Sweep datapath, committed setup and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_setup     <= SETUP_8W;
            r_target    <= SETUP_8W;
            r_sweep_set <= '0;
            r_pending   <= '0;
            r_wb_way    <= '0;
            r_cfg_ready <= 1'b1;
            r_cfg_done  <= 1'b0;
            r_stall     <= 1'b0;
            r_sweep_rd  <= 1'b0;
            r_wb_req    <= 1'b0;
            r_inval_we  <= 1'b0;
            r_plru_rst  <= 1'b0;
        end else begin
            r_cfg_ready <= w_cfg_ready;
            r_cfg_done  <= w_cfg_done;
            r_stall     <= w_stall;
            r_sweep_rd  <= w_sweep_rd;
            r_wb_req    <= w_wb_req;
            r_inval_we  <= w_inval_we;
            r_plru_rst  <= w_plru_rst;
            case (r_state)
                ST_IDLE:    if (cfg_req) r_target <= setup_t'(cfg_setup);
                ST_DRAIN:   if (cache_idle) r_sweep_set <= '0;
                ST_CAPTURE: r_pending <= line_valid & line_dirty;
                ST_SCAN:    if (!w_none) r_wb_way <= w_low_idx;
                ST_WB:      if (wb_ack) r_pending[r_wb_way] <= 1'b0;
                ST_INVAL:   if (!w_last_set) r_sweep_set <= r_sweep_set + SET_IDX_BITS'(1);
                ST_COMMIT:  r_setup <= r_target;
                default:    ;
            endcase
        end
    end

    assign cfg_ready   = r_cfg_ready;
    assign cfg_done    = r_cfg_done;
    assign stall_cache = r_stall;
    assign setup       = r_setup;
    assign sweep_set   = r_sweep_set;
    assign sweep_rd    = r_sweep_rd;
    assign wb_req      = r_wb_req;
    assign wb_way      = r_wb_way;
    assign inval_we    = r_inval_we;
    assign plru_rst    = r_plru_rst;

endmodule

// File: tb/tb_mutative_reconfig_ctrl.sv
// Bench for mutative_reconfig_ctrl: array/ack responders, a table of
// reconfigurations, a reset-during-writeback sequence and random runs.
module tb_mutative_reconfig_ctrl;
    import mutative_types::*;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    cfg_req = 1'b0;
    logic [1:0]              cfg_setup = 2'b00;
    logic                    cfg_ready, cfg_done, stall_cache, sweep_rd, wb_req, inval_we, plru_rst;
    logic                    cache_idle = 1'b1;
    logic [1:0]              setup;
    logic [SET_IDX_BITS-1:0] sweep_set;
    logic [WAYS-1:0]         line_valid = '0;
    logic [WAYS-1:0]         line_dirty = '0;
    logic [WAY_IDX_BITS-1:0] wb_way;
    logic                    wb_ack = 1'b0;

    logic [WAYS-1:0] mem_v [SET_SIZE];
    logic [WAYS-1:0] mem_d [SET_SIZE];
    int              ack_delay = 0;
    int              ack_cnt = 0;
    int              got_wb[$];

    int         errors = 0;
    int         checks = 0;
    logic [1:0] model_setup = 2'b11;

    always #5 clk = ~clk;

    mutative_reconfig_ctrl dut (
        .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_setup(cfg_setup),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cache_idle(cache_idle),
        .stall_cache(stall_cache), .setup(setup), .sweep_set(sweep_set),
        .sweep_rd(sweep_rd), .line_valid(line_valid), .line_dirty(line_dirty),
        .wb_req(wb_req), .wb_way(wb_way), .wb_ack(wb_ack),
        .inval_we(inval_we), .plru_rst(plru_rst)
    );

    // Tag-array read port and writeback responder, acting between edges.
    always @(negedge clk) begin
        if (sweep_rd) begin
            line_valid = mem_v[sweep_set];
            line_dirty = mem_d[sweep_set];
        end
        if (wb_req && !wb_ack) begin
            ack_cnt = ack_cnt + 1;
            if (ack_cnt > ack_delay) begin
                wb_ack = 1'b1;
                got_wb.push_back(int'(sweep_set) * int'(WAYS) + int'(wb_way));
            end
        end else begin
            ack_cnt = 0;
            wb_ack  = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // 0 clean, 1 set5 valid FF dirty 24, 2 set0 dirty but invalid, 3 random, 4 set7 one dirty line
    task automatic fill(input int mode);
        for (int s = 0; s < int'(SET_SIZE); s++) begin
            mem_v[s] = '0;
            mem_d[s] = '0;
            if (mode == 3) begin
                mem_v[s] = WAYS'($urandom);
                mem_d[s] = WAYS'($urandom & $urandom & $urandom);
            end
        end
        if (mode == 1) begin mem_v[5] = 8'hFF; mem_d[5] = 8'h24; end
        if (mode == 2) begin mem_v[0] = 8'h00; mem_d[0] = 8'h01; end
        if (mode == 4) begin mem_v[7] = 8'h01; mem_d[7] = 8'h01; end
    endtask

    function automatic int model_nwb();
        int n = 0;
        for (int s = 0; s < int'(SET_SIZE); s++)
            for (int w = 0; w < int'(WAYS); w++)
                if (mem_v[s][w] && mem_d[s][w]) n++;
        return n;
    endfunction

    // Issue one request at the current cycle (cycle 0) and check the whole run.
    task automatic run_cfg(input string tag, input logic [1:0] tgt, input int idle_hold,
                           input int dly, input int exp_done, input int exp_nwb);
        int  exp_wb[$];
        int  rd_sets[$];
        int  inv_sets[$];
        int  c = 0, done_c = -1, stall_n = 0, plru_n = 0, first_rd = -1;
        int  unstable = 0, wbreq_n = 0, bad = 0, base;
        bit  same;
        logic prev_req = 1'b0;
        logic [WAY_IDX_BITS-1:0] prev_way = '0;
        logic [SET_IDX_BITS-1:0] prev_set = '0;

        same = (tgt == model_setup);
        if (!same)
            for (int s = 0; s < int'(SET_SIZE); s++)
                for (int w = 0; w < int'(WAYS); w++)
                    if (mem_v[s][w] && mem_d[s][w]) exp_wb.push_back(s * int'(WAYS) + w);
        base = got_wb.size();
        ack_delay = dly;
        chk({tag, " ready_pre"}, int'(cfg_ready), 1);
        cfg_setup  = tgt;
        cfg_req    = 1'b1;
        cache_idle = 1'b0;
        while (done_c < 0 && c < 3000) begin
            @(posedge clk); #1;
            c++;
            cfg_req = 1'b0;
            if (stall_cache) stall_n++;
            if (plru_rst) plru_n++;
            if (wb_req) wbreq_n++;
            if (sweep_rd) begin
                rd_sets.push_back(int'(sweep_set));
                if (first_rd < 0) first_rd = c;
            end
            if (inval_we) inv_sets.push_back(int'(sweep_set));
            if (wb_req && prev_req && (wb_way != prev_way || sweep_set != prev_set)) unstable++;
            prev_req = wb_req; prev_way = wb_way; prev_set = sweep_set;
            if (cfg_done) done_c = c;
            cache_idle = (c > idle_hold);
        end
        chk({tag, " done_cycle"}, done_c, exp_done);
        chk({tag, " stall_cycles"}, stall_n, same ? 0 : exp_done);
        chk({tag, " plru_pulses"}, plru_n, same ? 0 : 1);
        chk({tag, " first_rd"}, first_rd, same ? -1 : idle_hold + 2);
        chk({tag, " rd_count"}, rd_sets.size(), same ? 0 : int'(SET_SIZE));
        chk({tag, " inval_count"}, inv_sets.size(), same ? 0 : int'(SET_SIZE));
        for (int i = 0; i < rd_sets.size(); i++) if (rd_sets[i] != i) bad++;
        for (int i = 0; i < inv_sets.size(); i++) if (inv_sets[i] != i) bad++;
        chk({tag, " set_order"}, bad, 0);
        chk({tag, " wb_count"}, got_wb.size() - base, exp_nwb);
        chk({tag, " wb_model_count"}, exp_wb.size(), exp_nwb);
        bad = 0;
        for (int i = 0; i < exp_wb.size() && base + i < got_wb.size(); i++)
            if (got_wb[base + i] != exp_wb[i]) bad++;
        chk({tag, " wb_order"}, bad, 0);
        chk({tag, " wb_req_cycles"}, wbreq_n, exp_nwb * (dly + 1));
        chk({tag, " wb_stable"}, unstable, 0);
        @(posedge clk); #1;
        chk({tag, " stall_after"}, int'(stall_cache), 0);
        chk({tag, " setup_after"}, int'(setup), int'(tgt));
        chk({tag, " ready_after"}, int'(cfg_ready), 1);
        chk({tag, " done_after"}, int'(cfg_done), 0);
        model_setup = tgt;
    endtask

    typedef struct {
        logic [1:0] tgt;
        int         idle_hold;
        int         dly;
        int         fill_mode;
        int         exp_done;
        int         exp_nwb;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int found;
        int n, idle, dly;
        logic [1:0] tgt;

        vecs[0] = '{2'b11, 0,  0, 0, 1,  0};
        vecs[1] = '{2'b10, 0,  0, 0, 66, 0};
        vecs[2] = '{2'b10, 0,  0, 0, 1,  0};
        vecs[3] = '{2'b01, 10, 0, 0, 76, 0};
        vecs[4] = '{2'b00, 0,  3, 1, 76, 2};
        vecs[5] = '{2'b01, 0,  0, 2, 66, 0};

        #1 rst = 1'b1;
        #2;
        chk("rst cfg_ready", int'(cfg_ready), 1);
        chk("rst setup", int'(setup), 3);
        chk("rst stall", int'(stall_cache), 0);
        chk("rst outputs", int'({cfg_done, sweep_rd, wb_req, inval_we, plru_rst}), 0);
        chk("rst sweep_set", int'(sweep_set), 0);
        chk("rst wb_way", int'(wb_way), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            fill(vecs[i].fill_mode);
            run_cfg($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].idle_hold,
                    vecs[i].dly, vecs[i].exp_done, vecs[i].exp_nwb);
        end

        // Reset while a writeback at set 7 is outstanding.
        fill(4);
        ack_delay  = 100000;
        cfg_setup  = 2'b10;
        cfg_req    = 1'b1;
        cache_idle = 1'b1;
        found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            @(posedge clk); #1;
            cfg_req = 1'b0;
            if (wb_req && sweep_set == SET_IDX_BITS'(7)) found = 1;
        end
        chk("rstwb reached", found, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstwb wb_req", int'(wb_req), 0);
        chk("rstwb stall", int'(stall_cache), 0);
        chk("rstwb setup", int'(setup), 3);
        chk("rstwb cfg_ready", int'(cfg_ready), 1);
        chk("rstwb sweep_set", int'(sweep_set), 0);
        @(negedge clk) rst = 1'b0;
        model_setup = 2'b11;
        ack_delay   = 0;
        fill(0);
        @(posedge clk); #1;
        run_cfg("post_rst", 2'b10, 0, 0, 66, 0);

        for (int r = 0; r < 8; r++) begin
            tgt  = 2'($urandom_range(0, 3));
            idle = int'($urandom_range(0, 4));
            dly  = int'($urandom_range(0, 3));
            fill(3);
            n = model_nwb();
            if (tgt == model_setup)
                run_cfg($sformatf("rnd%0d", r), tgt, idle, dly, 1, 0);
            else
                run_cfg($sformatf("rnd%0d", r), tgt, idle, dly, idle + 2 + 4 * int'(SET_SIZE) + n * (2 + dly), n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mutative_reconfig_ctrl.md
Name: mutative_reconfig_ctrl

Overview:
- Sequences a run-time change of mutative cache associativity (direct-mapped, 2-way, 4-way or 8-way).
- Latches a configuration request, then stalls new cache accesses and waits for in-flight accesses to drain.
- Sweeps every set: writes back valid+dirty lines and invalidates the set.
- Clears replacement (PLRU) state, then commits the new `setup` code that drives the tag/way mapping and replacement logic.
- Sits between the cache controller and the tag/valid/dirty arrays and PLRU.

Parameters:
- WAYS, 8, physical ways; the 8-way configuration uses all of them.
- SET_SIZE, 16, number of sets.
- SET_IDX_BITS, $clog2(SET_SIZE), set index width.
- WAY_IDX_BITS, $clog2(WAYS), way index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_req  in  1  reconfiguration request
- cfg_setup  in  2  requested setup: 00 DM, 01 2-way, 10 4-way, 11 8-way
- cfg_ready  out  1  controller can accept cfg_req
- cfg_done  out  1  one-cycle pulse: request complete
- cache_idle  in  1  cache has no outstanding access
- stall_cache  out  1  block new cache accesses
- setup  out  2  committed configuration
- sweep_set  out  SET_IDX_BITS  set under sweep
- sweep_rd  out  1  read valid/dirty arrays at sweep_set
- line_valid  in  WAYS  valid bits of sweep_set, one cycle after sweep_rd
- line_dirty  in  WAYS  dirty bits, same timing as line_valid
- wb_req  out  1  write back line (sweep_set, wb_way)
- wb_way  out  WAY_IDX_BITS  way to write back
- wb_ack  in  1  writeback complete
- inval_we  out  1  clear valid+dirty of all ways of sweep_set
- plru_rst  out  1  clear all PLRU bits

Behaviour:
- Reset (asynchronous, any state):
  - state IDLE, setup=2'b11, sweep_set=0, pending mask=0.
  - cfg_ready=1; cfg_done, stall_cache, sweep_rd, wb_req, inval_we and plru_rst all 0; wb_way=0.
  - No resume of a partial sweep; system reset clears the arrays.
- All outputs are Moore (decoded from registered state/counters).
- States: IDLE, SAME, DRAIN, READ, CAPTURE, SCAN, WB, INVAL, COMMIT.
- IDLE:
  - cfg_ready=1; cfg_req is accepted when cfg_req && cfg_ready.
  - cfg_setup==setup: go to SAME. SAME pulses cfg_done for one cycle, asserts no stall and performs no sweep, then returns to IDLE.
  - Otherwise latch target=cfg_setup and go to DRAIN.
- stall_cache=1 in every state except IDLE and SAME.
- cfg_req outside IDLE is ignored (cfg_ready=0).
- DRAIN: wait for cache_idle=1, then go to READ with sweep_set=0.
- READ: sweep_rd=1 for one cycle, then go to CAPTURE.
- CAPTURE: pending <= line_valid & line_dirty, then go to SCAN.
- SCAN:
  - pending==0: go to INVAL.
  - Otherwise wb_way <= index of the lowest set bit of pending, then go to WB.
- WB:
  - wb_req=1; wb_way and sweep_set are held stable until wb_ack.
  - On wb_ack, clear that pending bit and go to SCAN.
  - wb_ack outside WB is ignored.
- INVAL:
  - inval_we=1 for one cycle.
  - sweep_set==SET_SIZE-1: go to COMMIT.
  - Otherwise sweep_set increments and the FSM goes to READ. No wrap-around; the sweep ends at the last set.
- COMMIT:
  - plru_rst=1 and cfg_done=1 for one cycle.
  - setup <= target at the end of the cycle; the next state is IDLE, so stall_cache drops the following cycle.
- setup changes only in COMMIT, so the mapping is never altered while accesses are live.
- Timing with cache_idle already high and no dirty lines:
  - Accept at cycle 0, DRAIN at cycle 1, each set takes 4 cycles, COMMIT at cycle 2+4*SET_SIZE (66 for the defaults).
  - Each dirty line adds 2 cycles plus the ack wait (ack in the first WB cycle means exactly +2).

Decomposition:
- mutative_types package:
  - setup_t enum (SETUP_DM=2'b00, SETUP_2W, SETUP_4W, SETUP_8W).
  - reconfig_state_t enum.
  - WAYS, SET_SIZE, SET_IDX_BITS and WAY_IDX_BITS constants, shared with the PLRU and the arrays.
- One natural sub-module: mutative_prio_enc, a lowest-set-bit priority encoder over WAYS bits producing an index and a none-flag.

Test Plan:
- Reset, then cfg_req with cfg_setup=2'b11 -> cfg_done at cycle 1; stall_cache, sweep_rd and plru_rst never assert; setup stays 2'b11.
- cache_idle=1, all lines clean, cfg_setup=2'b10 -> DRAIN at cycle 1; sixteen sweep_rd/inval_we pairs for sets 0..15; plru_rst and cfg_done at cycle 66; setup=2'b10 at cycle 67; stall_cache 1 from cycle 1 to 66.
- cache_idle held 0 for 10 cycles -> no sweep_rd until cache_idle rises; the sweep then starts on the next cycle.
- Set 5 with valid=8'hFF, dirty=8'h24; wb_ack delayed 3 cycles -> wb_req for way 2 then way 5, each held 4 cycles with wb_way and sweep_set=5 stable; then inval_we for set 5.
- Line dirty but not valid (valid=0, dirty=8'h01) -> no wb_req.
- rst asserted while in WB at set 7 -> immediately wb_req=0, stall_cache=0, setup=2'b11, cfg_ready=1; a later cfg_req sweeps from set 0.
